// File: rtl/win_ewmul_acc.sv
// Winograd element-wise multiply-accumulate: V (.) U products summed over input channels.
// Optional build macro WIN_ACC_SAT_EN selects saturating accumulation instead of wrap-around.
module win_ewmul_acc #(
  parameter int DW   = 16,
  parameter int NE   = 16,
  parameter int NMUL = 4,
  parameter int AW   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [NE*DW-1:0] v_tile,
  input  logic [NE*DW-1:0] u_tile,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NE*AW-1:0] m_tile,
  output logic             busy,
  output logic             ovf
);

  localparam int NB = NE / NMUL;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  generate
    if ((NE % NMUL) != 0) begin : g_cfg_err_ne
      $error("win_ewmul_acc: NE must be an exact multiple of NMUL");
    end
    if (AW < 2 * DW) begin : g_cfg_err_aw
      $error("win_ewmul_acc: AW must be at least 2*DW");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_OUT = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [NE*DW-1:0]  v_reg, u_reg;
  logic              first_reg, last_reg;
  logic [BW-1:0]     beat_reg;
  logic [NE*AW-1:0]  acc_reg, m_tile_reg;
  logic              out_valid_reg, ovf_reg;

  logic [NMUL*AW-1:0] prod_flat;
  logic [NE*AW-1:0]   elem_next;
  logic [NE-1:0]      elem_act, elem_of;

  logic last_beat, accept, handshake;
  assign last_beat = (beat_reg == BW'(NB - 1));
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_reg && out_ready;

  // One multiplier per lane; the beat counter picks which slice of the tile it sees.
  genvar gi;
  generate
    for (gi = 0; gi < NMUL; gi++) begin : g_lane
      logic signed [DW-1:0]   v_op, u_op;
      logic signed [2*DW-1:0] prod;
      assign v_op = v_reg[(int'(beat_reg) * NMUL + gi) * DW +: DW];
      assign u_op = u_reg[(int'(beat_reg) * NMUL + gi) * DW +: DW];
      assign prod = (2*DW)'(v_op) * (2*DW)'(u_op);
      assign prod_flat[gi*AW +: AW] = AW'(prod);
    end

    for (gi = 0; gi < NE; gi++) begin : g_elem
      localparam int LANE = gi % NMUL;
      localparam int BEAT = gi / NMUL;
      logic signed [AW-1:0] acc_e, prod_e, sum_e, next_e;
      logic                 of_e;
      assign acc_e  = acc_reg[gi*AW +: AW];
      assign prod_e = prod_flat[LANE*AW +: AW];
      assign sum_e  = acc_e + prod_e;
      // Signed overflow: operands share a sign that the sum does not.
      assign of_e   = !first_reg && (acc_e[AW-1] == prod_e[AW-1]) && (sum_e[AW-1] != acc_e[AW-1]);
`ifdef WIN_ACC_SAT_EN
      assign next_e = first_reg ? prod_e :
                      of_e      ? (acc_e[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}) :
                                  sum_e;
`else
      assign next_e = first_reg ? prod_e : sum_e;
`endif
      assign elem_act[gi] = (state_reg == S_MUL) && (beat_reg == BW'(BEAT));
      assign elem_of[gi]  = elem_act[gi] && of_e;
      assign elem_next[gi*AW +: AW] = elem_act[gi] ? next_e : acc_e;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_MUL;
      S_MUL:   if (last_beat) state_next = last_reg ? S_OUT : S_IDLE;
      S_OUT:   if (handshake) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_reg == S_IDLE) in_ready = rst_n;
    else                     busy     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg         <= '0;
      u_reg         <= '0;
      first_reg     <= 1'b0;
      last_reg      <= 1'b0;
      beat_reg      <= '0;
      acc_reg       <= '0;
      m_tile_reg    <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            v_reg     <= v_tile;
            u_reg     <= u_tile;
            first_reg <= in_first;
            last_reg  <= in_last;
            beat_reg  <= '0;
          end
        end
        S_MUL: begin
          acc_reg <= elem_next;
          ovf_reg <= ovf_reg | (|elem_of);
          if (!last_beat) begin
            beat_reg <= beat_reg + 1'b1;
          end else if (last_reg) begin
            m_tile_reg    <= elem_next;
            out_valid_reg <= 1'b1;
          end
        end
        S_OUT: begin
          if (handshake) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign m_tile    = m_tile_reg;
  assign ovf       = ovf_reg;

endmodule

// File: doc/win_ewmul_acc.md
Name: win_ewmul_acc

Overview:
- Parametrised successor to the Winograd element-wise multiply stage of the LeNet accelerator.
- Multiplies a transformed input tile V by a transformed kernel tile U, element by element, and accumulates the products across input channels.
- Uses a configurable number of multipliers time-shared over the tile.
- Sits between the V/U transform stages and the output (A-transform) stage, with valid/ready handshakes on both sides.

Parameters:
- DW, 16: signed element width of V and U.
- NE, 16: elements per tile (4x4 Winograd tile).
- NMUL, 4: parallel multipliers. NE must be an exact multiple of NMUL.
- AW, 40: signed accumulator/output element width. AW must be at least 2*DW.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  tile pair offered.
- in_ready  out  1  block can accept a tile pair.
- in_first  in  1  first input channel of this output tile; qualified by in_valid.
- in_last  in  1  last input channel; completes the output tile.
- v_tile  in  NE*DW  V elements; element i at [i*DW +: DW].
- u_tile  in  NE*DW  U elements; same ordering as v_tile.
- out_valid  out  1  accumulated tile available.
- out_ready  in  1  downstream accepts the tile.
- m_tile  out  NE*AW  accumulated products; element i at [i*AW +: AW].
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky accumulator overflow flag for the current output tile.

Behaviour:
- Reset values: in_ready=0 while rst_n low, 1 after release. out_valid=0, m_tile=0, busy=0, ovf=0. Accumulator, captured tiles, flags, beat counter and state are all cleared. State=IDLE.
- State IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid&&in_ready: capture v_tile, u_tile, in_first, in_last; clear beat counter; go to MUL.
- State MUL:
  - in_ready=0. Runs NB=NE/NMUL beats, one per edge.
  - Beat b processes elements b*NMUL .. b*NMUL+NMUL-1.
  - Each product is a full-precision signed DW x DW multiply giving 2*DW bits, sign-extended to AW.
  - If the captured first flag is set, the product replaces acc[i]. Otherwise it is added to acc[i].
  - On the last beat:
    - Last flag set: load m_tile from the final accumulator values (including this beat's results), set out_valid, go to OUT.
    - Last flag clear: go to IDLE.
- Latency: out_valid rises NB edges after the accepting edge (4 with defaults). A non-last tile returns to IDLE after NB edges, so in_ready is low for NB cycles per tile.
- State OUT:
  - in_ready=0. out_valid, m_tile and ovf are held stable while out_ready=0.
  - On an edge with out_valid&&out_ready: clear out_valid, clear the accumulator, clear ovf, go to IDLE. in_ready is 1 in the next cycle.
- Boundary conditions:
  - in_first and in_last both set: a single-channel tile; the output equals the products.
  - in_first=0 on the first tile after an output: accumulates onto the zeroed accumulator, same result as first=1.
  - in_valid in MUL/OUT is ignored (not captured). Inputs need only be stable on the accepting edge.
  - Accumulator overflow without the optional feature: two's-complement wrap modulo 2^AW.
  - ovf is set when any element's signed add overflows, in either build.
  - rst_n asserted mid-MUL or mid-OUT: immediate return to reset values; the partial tile is discarded.
- Parameter rule: NE%NMUL!=0 is a configuration error; elaboration fails via a generate-time check.

Optional Feature:
- Macro WIN_ACC_SAT_EN.
- Defined: on signed add overflow, acc[i] saturates to 2^(AW-1)-1 (positive overflow) or -2^(AW-1) (negative overflow), and ovf is set.
- Undefined: wrap-around arithmetic, ovf still set, no saturation logic built.

Test Plan:
- Single tile: first=1, last=1, all V=3, all U=-2 -> m_tile all elements -6 (AW-bit sign-extended), out_valid rises exactly 4 edges after accept, ovf=0.
- Three channels: V[i]=i, U=1,2,3 per channel, first on channel 1, last on channel 3 -> m[i]=6i for i=0..15. in_ready is low for 4 cycles after each accept, and out_valid appears only after channel 3.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> m_tile/out_valid unchanged and in_ready=0 throughout; raise out_ready -> out_valid drops next edge, and a new first tile accumulates from 0.
- Extremes: all V=-32768, all U=-32768 -> all m=1073741824. Mixed V=-32768, U=32767 -> -1073709056.
- Overflow with AW=32, three channels of (-32768*-32768): WIN_ACC_SAT_EN defined -> m=0x7FFFFFFF, ovf=1. Macro undefined -> m=0xC0000000, ovf=1.
- Reset mid-MUL (rst_n low at beat 2) -> all outputs zero immediately, in_ready=1 after release; next single tile V=5, U=7 -> m all 35.
